// File: rtl/test_sequencer.sv
// Hardware test sequencer: starts each enabled channel in ascending order, enforces a per-test
// timeout and records pass/fail/timeout bitmaps. Define TSEQ_STOP_ON_FAIL_EN to stop at first bad.
module test_sequencer #(
  parameter int unsigned NUM_TESTS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned CurW          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 run_i,
  input  logic [NUM_TESTS-1:0] enable_mask_i,
  output logic [NUM_TESTS-1:0] test_start_o,
  input  logic [NUM_TESTS-1:0] test_done_i,
  input  logic [NUM_TESTS-1:0] test_pass_i,
  output logic                 busy_o,
  output logic                 all_done_o,
  output logic [CurW-1:0]      cur_test_o,
  output logic [NUM_TESTS-1:0] pass_map_o,
  output logic [NUM_TESTS-1:0] fail_map_o,
  output logic [NUM_TESTS-1:0] timeout_map_o,
  output logic                 summary_pass_o
);

`ifdef TSEQ_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  // Counter starts at 0 in the first WAIT cycle, so T-2 marks the last cycle a done is accepted.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 32'd2);

  typedef enum logic [2:0] {StIdle, StSelect, StStart, StWait, StNext, StFinish} state_e;

  state_e               state_q, state_d;
  logic [NUM_TESTS-1:0] mask_q, mask_d;
  logic [NUM_TESTS-1:0] pass_q, pass_d;
  logic [NUM_TESTS-1:0] fail_q, fail_d;
  logic [NUM_TESTS-1:0] tout_q, tout_d;
  logic [CurW-1:0]      cur_q, cur_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sum_q, sum_d;

  logic [CurW-1:0]      found_idx;
  logic                 found;
  logic [NUM_TESTS-1:0] cur_onehot;
  logic                 done_cur, pass_cur, result_bad;

  assign cur_onehot = NUM_TESTS'(1) << cur_q;
  assign done_cur   = |(test_done_i & cur_onehot);
  assign pass_cur   = |(test_pass_i & cur_onehot);

  // Lowest pending channel at or above the current index.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = int'(NUM_TESTS) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(cur_q))) begin
        found     = 1'b1;
        found_idx = CurW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    tout_d       = tout_q;
    sum_d        = sum_q;
    test_start_o = '0;
    all_done_o   = 1'b0;
    result_bad   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          mask_d  = enable_mask_i;
          pass_d  = '0;
          fail_d  = '0;
          tout_d  = '0;
          sum_d   = 1'b0;
          cur_d   = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (found) begin
          cur_d   = found_idx;
          state_d = StStart;
        end else begin
          state_d = StFinish;
        end
      end
      StStart: begin
        test_start_o = cur_onehot;
        cnt_d        = '0;
        state_d      = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Done is checked first so a done coinciding with the deadline still counts.
        if (done_cur) begin
          if (pass_cur) begin
            pass_d = pass_q | cur_onehot;
          end else begin
            fail_d     = fail_q | cur_onehot;
            result_bad = 1'b1;
          end
          state_d = StNext;
        end else if (cnt_q == TimeoutLast) begin
          tout_d     = tout_q | cur_onehot;
          result_bad = 1'b1;
          state_d    = StNext;
        end
        if (StopOnFail && result_bad) begin
          state_d = StFinish;
        end
      end
      StNext: begin
        mask_d  = mask_q & ~cur_onehot;
        state_d = StSelect;
      end
      StFinish: begin
        all_done_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Verdict is registered on entry to FINISH so it is valid alongside all_done.
    if (state_d == StFinish && state_q != StFinish) begin
      sum_d = ~|fail_d && ~|tout_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mask_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      tout_q  <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tout_q  <= tout_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign cur_test_o     = cur_q;
  assign pass_map_o     = pass_q;
  assign fail_map_o     = fail_q;
  assign timeout_map_o  = tout_q;
  assign summary_pass_o = sum_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Randomised bench for test_sequencer: a schedule model predicts every output on every cycle.
module tb_test_sequencer;
  localparam int N    = 16;
  localparam int T    = 8;
  localparam int CurW = 4;

`ifdef TSEQ_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run;
  logic [N-1:0]    enable_mask, test_start, test_done, test_pass;
  logic            busy, all_done, summary_pass;
  logic [CurW-1:0] cur_test;
  logic [N-1:0]    pass_map, fail_map, timeout_map;

  test_sequencer #(
    .NUM_TESTS      (N),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .run_i          (run),
    .enable_mask_i  (enable_mask),
    .test_start_o   (test_start),
    .test_done_i    (test_done),
    .test_pass_i    (test_pass),
    .busy_o         (busy),
    .all_done_o     (all_done),
    .cur_test_o     (cur_test),
    .pass_map_o     (pass_map),
    .fail_map_o     (fail_map),
    .timeout_map_o  (timeout_map),
    .summary_pass_o (summary_pass)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  // Model: per-run schedule of start and decision cycles; outcome 0 pass, 1 fail, 2 timeout.
  bit              have_run = 1'b0;
  int              run_c, fin_c;
  int              start_c[N], dec_c[N], delay[N], outc[N];
  bit              ran[N], pv[N];
  logic [N-1:0]    prev_map[3];
  logic            prev_sum;
  logic [CurW-1:0] prev_cur;

  int start_seen[N];
  int done_seen, to1_seen;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic plan_run(input logic [N-1:0] mask, input int r);
    int t, last_dec;
    bit stop;
    t        = r + 2;
    last_dec = 0;
    stop     = 1'b0;
    run_c    = r;
    for (int ch = 0; ch < N; ch++) begin
      ran[ch] = 1'b0;
      if (mask[ch] && !stop) begin
        ran[ch]     = 1'b1;
        start_c[ch] = t;
        if (delay[ch] <= T - 1) begin
          dec_c[ch] = t + delay[ch];
          outc[ch]  = pv[ch] ? 0 : 1;
        end else begin
          dec_c[ch] = t + T - 1;
          outc[ch]  = 2;
        end
        last_dec = dec_c[ch];
        if (StopOnFail && outc[ch] != 0) stop = 1'b1;
        t = dec_c[ch] + 3;
      end
    end
    fin_c = stop ? last_dec + 1 : t;
  endtask

  function automatic logic [N-1:0] exp_map(input int c, input int kind);
    logic [N-1:0] m;
    if (!have_run || c <= run_c) return prev_map[kind];
    m = '0;
    for (int ch = 0; ch < N; ch++)
      if (ran[ch] && dec_c[ch] < c && outc[ch] == kind) m[ch] = 1'b1;
    return m;
  endfunction

  function automatic logic exp_sum(input int c);
    if (!have_run || c <= run_c) return prev_sum;
    if (c < fin_c) return 1'b0;
    for (int ch = 0; ch < N; ch++)
      if (ran[ch] && outc[ch] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [CurW-1:0] exp_cur(input int c);
    int best;
    if (!have_run || c <= run_c) return prev_cur;
    best = -1;
    for (int ch = 0; ch < N; ch++)
      if (ran[ch] && start_c[ch] <= c) best = ch;
    return (best < 0) ? '0 : CurW'(best);
  endfunction

  function automatic logic [N-1:0] exp_start(input int c);
    logic [N-1:0] m;
    m = '0;
    if (have_run)
      for (int ch = 0; ch < N; ch++)
        if (ran[ch] && start_c[ch] == c) m[ch] = 1'b1;
    return m;
  endfunction

  always @(negedge clk) begin
    check("test_start", 64'(test_start), 64'(exp_start(cyc)));
    check("busy", 64'(busy), 64'(have_run && cyc > run_c && cyc <= fin_c));
    check("all_done", 64'(all_done), 64'(have_run && cyc == fin_c));
    check("cur_test", 64'(cur_test), 64'(exp_cur(cyc)));
    check("pass_map", 64'(pass_map), 64'(exp_map(cyc, 0)));
    check("fail_map", 64'(fail_map), 64'(exp_map(cyc, 1)));
    check("timeout_map", 64'(timeout_map), 64'(exp_map(cyc, 2)));
    check("summary_pass", 64'(summary_pass), 64'(exp_sum(cyc)));
    if (all_done === 1'b1) begin
      done_seen = cyc;
      done_cnt++;
    end
    for (int ch = 0; ch < N; ch++)
      if (test_start[ch] === 1'b1) start_seen[ch] = cyc;
    if (timeout_map[1] === 1'b1 && to1_seen < 0) to1_seen = cyc;
  end

  task automatic step(input bit run_v, input bit accept, input logic [N-1:0] mask);
    logic [N-1:0] d, p, g;
    @(posedge clk);
    cyc++;
    if (accept) begin
      for (int k = 0; k < 3; k++) prev_map[k] = exp_map(cyc, k);
      prev_sum = exp_sum(cyc);
      prev_cur = exp_cur(cyc);
      have_run = 1'b1;
      plan_run(mask, cyc);
    end
    #1;
    d = N'($urandom & $urandom);
    p = N'($urandom);
    g = '0;
    // Noise may hit any channel except the one whose done window is open.
    for (int ch = 0; ch < N; ch++)
      if (have_run && ran[ch] && cyc > start_c[ch] && cyc <= dec_c[ch]) g[ch] = 1'b1;
    d = d & ~g;
    for (int ch = 0; ch < N; ch++)
      if (have_run && ran[ch] && delay[ch] <= T - 1 && cyc == start_c[ch] + delay[ch]) begin
        d[ch] = 1'b1;
        p[ch] = pv[ch];
      end
    test_done   = d;
    test_pass   = p;
    run         = run_v;
    enable_mask = accept ? mask : N'($urandom);
  endtask

  task automatic do_run(input logic [N-1:0] mask, input bit noisy);
    for (int ch = 0; ch < N; ch++) start_seen[ch] = -1;
    done_seen = -1;
    to1_seen  = -1;
    step(1'b1, 1'b1, mask);
    while (cyc < fin_c) step(noisy && ($urandom_range(0, 7) == 0), 1'b0, '0);
    @(negedge clk);
    #1;
  endtask

  task automatic rand_delays();
    for (int ch = 0; ch < N; ch++) begin
      delay[ch] = $urandom_range(1, T + 1);
      pv[ch]    = 1'($urandom_range(0, 1));
    end
  endtask

  int n0;

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    test_done = '0;
    test_pass = '0;
    enable_mask = '0;
    prev_map[0] = '0;
    prev_map[1] = '0;
    prev_map[2] = '0;
    prev_sum = 1'b0;
    prev_cur = '0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, '0);

    // Two passing channels.
    rand_delays();
    delay[0] = 5; pv[0] = 1'b1;
    delay[2] = 7; pv[2] = 1'b1;
    n0 = done_cnt;
    do_run(16'h0005, 1'b0);
    check("s1 start0", 64'(start_seen[0] - run_c), 64'd2);
    check("s1 start2", 64'(start_seen[2] - run_c), 64'd10);
    check("s1 done at", 64'(done_seen - run_c), 64'd20);
    check("s1 done count", 64'(done_cnt - n0), 64'd1);
    check("s1 pass_map", 64'(pass_map), 64'h0005);
    check("s1 summary", 64'(summary_pass), 64'd1);

    // Fail then timeout.
    rand_delays();
    delay[0] = 3; pv[0] = 1'b0;
    delay[1] = 99;
    do_run(16'h0003, 1'b0);
    check("s2 fail_map", 64'(fail_map), 64'h0001);
    check("s2 summary", 64'(summary_pass), 64'd0);
`ifndef TSEQ_STOP_ON_FAIL_EN
    check("s2 timeout_map", 64'(timeout_map), 64'h0002);
    check("s2 timeout delay", 64'(to1_seen - start_seen[1]), 64'd8);
`endif

    // Done on the deadline cycle.
    rand_delays();
    delay[3] = T - 1; pv[3] = 1'b1;
    do_run(16'h0008, 1'b0);
    check("s3 pass_map", 64'(pass_map), 64'h0008);
    check("s3 timeout_map", 64'(timeout_map), 64'h0000);

    // Empty mask.
    do_run(16'h0000, 1'b1);
    check("s4 done at", 64'(done_seen - run_c), 64'd2);
    check("s4 summary", 64'(summary_pass), 64'd1);

    // Long sequence with stray run pulses, then random sequences.
    rand_delays();
    do_run(16'hFFFF, 1'b1);
    for (int r = 0; r < 12; r++) begin
      rand_delays();
      do_run(N'($urandom | $urandom), 1'b1);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, '0);
    end

    // Channel 1 fails in a four-channel run.
    for (int ch = 0; ch < N; ch++) begin
      delay[ch] = 2;
      pv[ch]    = 1'b1;
    end
    pv[1] = 1'b0;
    do_run(16'h000F, 1'b0);
    check("s6 fail_map", 64'(fail_map), 64'h0002);
`ifdef TSEQ_STOP_ON_FAIL_EN
    check("s6 pass_map", 64'(pass_map), 64'h0001);
    check("s6 no start2", 64'(start_seen[2]), 64'(-1));
    check("s6 no start3", 64'(start_seen[3]), 64'(-1));
`else
    check("s6 pass_map", 64'(pass_map), 64'h000D);
`endif

    // Asynchronous reset while waiting on channel 4.
    delay[4] = 99;
    step(1'b1, 1'b1, 16'h0010);
    while (cyc < start_c[4] + 3) step(1'b0, 1'b0, '0);
    check("s5 cur before reset", 64'(cur_test), 64'd4);
    @(posedge clk);
    cyc++;
    have_run = 1'b0;
    prev_map[0] = '0;
    prev_map[1] = '0;
    prev_map[2] = '0;
    prev_sum = 1'b0;
    prev_cur = '0;
    #1;
    test_done = '0;
    rst_n = 1'b0;
    #1;
    check("s5 rst busy", 64'(busy), 64'd0);
    check("s5 rst cur", 64'(cur_test), 64'd0);
    check("s5 rst start", 64'(test_start), 64'd0);
    check("s5 rst maps", 64'({pass_map, fail_map, timeout_map}), 64'd0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
    delay[0] = 2; pv[0] = 1'b1;
    do_run(16'h0001, 1'b0);
    check("s5 restart start0", 64'(start_seen[0] - run_c), 64'd2);
    check("s5 restart pass", 64'(pass_map), 64'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
